// File: rtl/tank_plant_pkg.sv
// tank_plant_pkg: shared defaults, sensor encoding and threshold helper for the tank plant
package tank_plant_pkg;
  localparam int LEVEL_W_DEF    = 8;
  localparam int LEVEL_MAX_DEF  = 200;
  localparam int LOW_TH_DEF     = 50;
  localparam int HIGH_TH_DEF    = 150;
  localparam int PUMP_RATE_DEF  = 2;
  localparam int DRAIN_RATE_DEF = 1;
  localparam int DRAIN_DIV_DEF  = 4;
  localparam int INIT_LEVEL_DEF = 0;
  localparam int HYST_DEF       = 4;
  typedef enum logic [1:0] {
    SENS_EMPTY = 2'b00,
    SENS_LOW   = 2'b01,
    SENS_FULL  = 2'b11
  } sens_e;
  function automatic sens_e sense(int lvl, int low_th, int high_th);
    return lvl >= high_th ? SENS_FULL : lvl >= low_th ? SENS_LOW : SENS_EMPTY;
  endfunction
endpackage

// File: rtl/tank_plant_if.sv
// tank_plant_if: pump commands in, level sensors and status out
interface tank_plant_if
  import tank_plant_pkg::*;
#(
  parameter int LEVEL_W = LEVEL_W_DEF
);
  logic B1;
  logic B2;
  logic drain_en;
  logic I;
  logic S;
  logic [LEVEL_W-1:0] level;
  logic overflow;
  logic dry;
  modport master (output B1, B2, drain_en, input I, S, level, overflow, dry);
  modport slave (input B1, B2, drain_en, output I, S, level, overflow, dry);
endinterface

// File: rtl/tank_drain_tick.sv
// tank_drain_tick: divides drain_en into one tick every DRAIN_DIV cycles, restarting when drain_en drops
module tank_drain_tick
  import tank_plant_pkg::*;
#(
  parameter int DRAIN_DIV = DRAIN_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic drain_en,
  output logic drain_tick
);
  localparam int CW = DRAIN_DIV > 1 ? $clog2(DRAIN_DIV) : 1;
  logic [CW-1:0] cnt;
  assign drain_tick = drain_en && cnt == CW'(DRAIN_DIV - 1);
  // count consumption cycles, wrapping on the tick
  always_ff @(posedge clk)
    cnt <= (reset || !drain_en || drain_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/tank_plant.sv
// tank_plant: water tank model with saturating level and I/S sensors; TANK_PLANT_HYST_EN adds sensor hysteresis
module tank_plant
  import tank_plant_pkg::*;
#(
  parameter int LEVEL_W    = LEVEL_W_DEF,
  parameter int LEVEL_MAX  = LEVEL_MAX_DEF,
  parameter int LOW_TH     = LOW_TH_DEF,
  parameter int HIGH_TH    = HIGH_TH_DEF,
  parameter int PUMP_RATE  = PUMP_RATE_DEF,
  parameter int DRAIN_RATE = DRAIN_RATE_DEF,
  parameter int DRAIN_DIV  = DRAIN_DIV_DEF,
`ifdef TANK_PLANT_HYST_EN
  parameter int HYST       = HYST_DEF,
`endif
  parameter int INIT_LEVEL = INIT_LEVEL_DEF
) (
  input logic clk,
  input logic reset,
  tank_plant_if.slave bus
);
  localparam int SW = LEVEL_W + 2;
  logic tick;
  logic signed [SW-1:0] sum;
  logic [LEVEL_W-1:0] next_level;
  logic over;
  logic under;
  logic i_next;
  logic s_next;
  tank_drain_tick #(.DRAIN_DIV(DRAIN_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .drain_en(bus.drain_en),
    .drain_tick(tick)
  );
  // single net step of pumps and drain, clamped to the tank range, then sensors from the new level
  always_comb begin
    sum = signed'({2'b00, bus.level}) + SW'(PUMP_RATE * (int'(bus.B1) + int'(bus.B2)))
        - (tick ? SW'(DRAIN_RATE) : SW'(0));
    over = sum > SW'(LEVEL_MAX);
    under = sum[SW-1];
    next_level = over ? LEVEL_W'(LEVEL_MAX) : under ? '0 : LEVEL_W'(sum);
`ifdef TANK_PLANT_HYST_EN
    i_next = int'(next_level) >= LOW_TH ? 1'b1 : int'(next_level) < LOW_TH - HYST ? 1'b0 : bus.I;
    s_next = int'(next_level) >= HIGH_TH ? 1'b1 : int'(next_level) < HIGH_TH - HYST ? 1'b0 : bus.S;
`else
    {s_next, i_next} = sense(int'(next_level), LOW_TH, HIGH_TH);
`endif
  end
  // level, sensors and sticky flags all update on the same edge
  always_ff @(posedge clk)
    if (reset) begin
      bus.level <= LEVEL_W'(INIT_LEVEL);
      {bus.S, bus.I} <= sense(INIT_LEVEL, LOW_TH, HIGH_TH);
      bus.overflow <= 1'b0;
      bus.dry <= 1'b0;
    end else begin
      bus.level <= next_level;
      bus.I <= i_next;
      bus.S <= s_next;
      bus.overflow <= bus.overflow | over;
      bus.dry <= bus.dry | under;
    end
endmodule
